// File: rtl/axi4_globals_pkg.sv
// AXI4 shared definitions: channel indices, response codes and payload layout helpers.
// Pure package; payload widths derive from address/data/id/user widths.
package axi4_globals_pkg;

   localparam int AXI4_CH_AW  = 0;
   localparam int AXI4_CH_W   = 1;
   localparam int AXI4_CH_B   = 2;
   localparam int AXI4_CH_AR  = 3;
   localparam int AXI4_CH_R   = 4;
   localparam int AXI4_NUM_CH = 5;

   typedef enum logic [1:0] {
      AXI4_RESP_OKAY   = 2'b00,
      AXI4_RESP_EXOKAY = 2'b01,
      AXI4_RESP_SLVERR = 2'b10,
      AXI4_RESP_DECERR = 2'b11
   } axi4_resp_e;

   // len(8)+size(3)+burst(2)+lock(1)+cache(4)+prot(3)+qos(4)+region(4)
   localparam int AXI4_AX_CTRL_W = 29;

   function automatic int axi4_ax_pld_w(input int aw, input int id, input int user);
      return id + aw + AXI4_AX_CTRL_W + user;
   endfunction

   function automatic int axi4_w_pld_w(input int dw, input int user);
      return dw + dw / 8 + 1 + user;
   endfunction

   function automatic int axi4_b_pld_w(input int id, input int user);
      return id + 2 + user;
   endfunction

   function automatic int axi4_r_pld_w(input int id, input int dw, input int user);
      return id + dw + 2 + 1 + user;
   endfunction

   function automatic int axi4_chan_pld_w(input int ch, input int aw, input int dw,
                                          input int id, input int user);
      case (ch)
         AXI4_CH_AW, AXI4_CH_AR: return axi4_ax_pld_w(aw, id, user);
         AXI4_CH_W:              return axi4_w_pld_w(dw, user);
         AXI4_CH_B:              return axi4_b_pld_w(id, user);
         default:                return axi4_r_pld_w(id, dw, user);
      endcase
   endfunction

   function automatic int axi4_chan_pld_off(input int ch, input int aw, input int dw,
                                            input int id, input int user);
      int off;
      off = 0;
      for (int c = 0; c < ch; c++) off += axi4_chan_pld_w(c, aw, dw, id, user);
      return off;
   endfunction

   function automatic int axi4_pld_total(input int aw, input int dw, input int id, input int user);
      return axi4_chan_pld_off(AXI4_NUM_CH, aw, dw, id, user);
   endfunction

endpackage

// File: rtl/axi4_chan_fifo.sv
// One buffered valid/ready channel: 1-cycle latency into empty, full rate with DEPTH>=2.
// in_ready/out_valid/out_pld are registered; no combinational path from out_ready to in_ready.
module axi4_chan_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   parameter int LW    = $clog2(DEPTH + 1)
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_pld,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_pld,
   output logic [LW-1:0]    level
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    count_q, count_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_pld_q, out_pld_d;
   logic             push, pop;

   always_comb begin
      push        = in_valid && in_ready_q;
      pop         = out_valid_q && out_ready;
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = in_pld;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d     = count_q + LW'(push) - LW'(pop);
      in_ready_d  = count_d < LW'(DEPTH);
      out_valid_d = count_d != '0;
      // A beat pushed while nothing else remains becomes the head directly.
      out_pld_d   = out_pld_q;
      if (push && (count_q == LW'(pop))) out_pld_d = in_pld;
      else if (count_d != '0)           out_pld_d = mem_q[rd_ptr_d];
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_pld_q   <= '0;
      end else begin
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_pld_q   <= out_pld_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_pld   = out_pld_q;
   assign level     = count_q;

endmodule

// File: rtl/axi4_reg_slice.sv
// AXI4 five-channel register slice; buffered channels add 1 cycle, pass-through channels add 0.
// Each channel backpressures independently through its own in_ready.
module axi4_reg_slice
   import axi4_globals_pkg::*;
#(
   parameter int          ADDRESS_WIDTH = 32,
   parameter int          DATA_WIDTH    = 32,
   parameter int          ID_WIDTH      = 4,
   parameter int          USER_WIDTH    = 4,
   parameter int          DEPTH         = 2,
   parameter logic [4:0]  CHAN_EN       = 5'b11111,
   localparam int         LW            = $clog2(DEPTH + 1),
   localparam int         PLD_TOTAL     = axi4_pld_total(ADDRESS_WIDTH, DATA_WIDTH,
                                                         ID_WIDTH, USER_WIDTH)
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic [4:0]           in_valid,
   output logic [4:0]           in_ready,
   input  logic [PLD_TOTAL-1:0] in_pld,
   output logic [4:0]           out_valid,
   input  logic [4:0]           out_ready,
   output logic [PLD_TOTAL-1:0] out_pld,
   output logic [5*LW-1:0]      level,
   output logic                 idle
);

   for (genvar c = 0; c < AXI4_NUM_CH; c++) begin : g_ch
      localparam int W   = axi4_chan_pld_w(c, ADDRESS_WIDTH, DATA_WIDTH, ID_WIDTH, USER_WIDTH);
      localparam int OFF = axi4_chan_pld_off(c, ADDRESS_WIDTH, DATA_WIDTH, ID_WIDTH, USER_WIDTH);

      if (CHAN_EN[c]) begin : g_buf
         axi4_chan_fifo #(
            .WIDTH (W),
            .DEPTH (DEPTH),
            .LW    (LW)
         ) u_fifo (
            .aclk      (aclk),
            .aresetn   (aresetn),
            .in_valid  (in_valid[c]),
            .in_ready  (in_ready[c]),
            .in_pld    (in_pld[OFF +: W]),
            .out_valid (out_valid[c]),
            .out_ready (out_ready[c]),
            .out_pld   (out_pld[OFF +: W]),
            .level     (level[c*LW +: LW])
         );
      end else begin : g_pass
         assign out_valid[c]         = in_valid[c];
         assign in_ready[c]          = out_ready[c];
         assign out_pld[OFF +: W]    = in_pld[OFF +: W];
         assign level[c*LW +: LW]    = '0;
      end
   end

   assign idle = (level == '0);

endmodule

// File: tb/tb_axi4_reg_slice.sv
module tb_axi4_reg_slice;

   localparam int PT  = 232;
   localparam int OFF [5] = '{0, 69, 110, 120, 189};
   localparam int WID [5] = '{69, 41, 10, 69, 43};

   logic          aclk, aresetn;
   logic [4:0]    in_valid, in_ready, out_valid, out_ready;
   logic [PT-1:0] in_pld, out_pld;
   logic [9:0]    level;
   logic          idle;

   logic [4:0]    in_valid2, in_ready2, out_valid2, out_ready2;
   logic [PT-1:0] in_pld2, out_pld2;
   logic [9:0]    level2;
   logic          idle2;

   axi4_reg_slice dut (
      .aclk(aclk), .aresetn(aresetn),
      .in_valid(in_valid), .in_ready(in_ready), .in_pld(in_pld),
      .out_valid(out_valid), .out_ready(out_ready), .out_pld(out_pld),
      .level(level), .idle(idle)
   );

   axi4_reg_slice #(.CHAN_EN(5'b11011)) dut_pt (
      .aclk(aclk), .aresetn(aresetn),
      .in_valid(in_valid2), .in_ready(in_ready2), .in_pld(in_pld2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_pld(out_pld2),
      .level(level2), .idle(idle2)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge aclk) cyc++;

   logic [68:0] drv_val [5];
   logic [68:0] exp_q [5][$];
   logic [31:0] w_seen [$];
   int          r_out_cyc [$];
   logic        r_last [$];
   int          r_in_first = -1;

   task automatic check(input string nm, input logic [68:0] act, input logic [68:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic logic [68:0] fld(input logic [PT-1:0] bus, input int c);
      logic [68:0] r;
      r = '0;
      for (int i = 0; i < 69; i++) if (i < WID[c]) r[i] = bus[OFF[c] + i];
      return r;
   endfunction

   task automatic drive(input int c, input logic [68:0] v);
      drv_val[c] = v;
      for (int i = 0; i < WID[c]; i++) in_pld[OFF[c] + i] = v[i];
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // Holds in_valid high until the beat is accepted; returns just after the accepting edge.
   task automatic send(input int c, input logic [68:0] v);
      bit ok;
      ok = 1'b0;
      drive(c, v);
      in_valid[c] = 1'b1;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge aclk);
         if (in_ready[c]) ok = 1'b1;
         @(posedge aclk);
         #1;
      end
      check($sformatf("send_accept_ch%0d", c), 69'(ok), 69'd1);
   endtask

   function automatic logic [68:0] r_beat(input int i);
      logic [31:0] d;
      d = 32'h100 + 32'(i);
      return 69'({4'h1, d, 2'b00, (i == 16), 4'h0});
   endfunction

   function automatic logic [68:0] ar_beat(input int i);
      logic [31:0] a;
      a = 32'h2000 + 32'(i);
      return {4'h7, a, 8'd0, 3'd2, 2'd1, 1'b0, 4'h0, 3'd0, 4'd0, 4'd0, 4'h0};
   endfunction

   // Scoreboard: expected beats are queued on acceptance and compared on each output handshake.
   always @(negedge aclk) begin
      logic [68:0] got;
      if (aresetn) begin
         for (int c = 0; c < 5; c++)
            if (in_valid[c] && in_ready[c]) begin
               exp_q[c].push_back(drv_val[c]);
               if (c == 4 && r_in_first < 0) r_in_first = cyc;
            end
         for (int c = 0; c < 5; c++)
            if (out_valid[c] && out_ready[c]) begin
               got = fld(out_pld, c);
               if (exp_q[c].size() == 0)
                  check($sformatf("sb_unexpected_ch%0d", c), got, 69'h0 - 69'h1);
               else
                  check($sformatf("sb_payload_ch%0d", c), got, exp_q[c].pop_front());
               if (c == 1) w_seen.push_back(got[40:9]);
               if (c == 4) begin
                  r_out_cyc.push_back(cyc);
                  r_last.push_back(got[4]);
               end
            end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1);
   end

   logic [68:0] aw_exp, tmp;

   initial begin
      aresetn    = 1'b0;
      in_valid   = '0;
      out_ready  = '0;
      in_pld     = '0;
      in_valid2  = '0;
      out_ready2 = '0;
      in_pld2    = '0;
      for (int c = 0; c < 5; c++) drv_val[c] = '0;

      // Reset state
      repeat (3) tick();
      check("rst_in_ready",  69'(in_ready), 69'h0);
      check("rst_out_valid", 69'(out_valid), 69'h0);
      check("rst_idle",      69'(idle), 69'h1);
      check("rst_level",     69'(level), 69'h0);
      check("rst_out_pld",   69'(out_pld == '0), 69'h1);
      aresetn = 1'b1;
      #1;
      check("rel_in_ready_before_edge", 69'(in_ready), 69'h0);
      tick();
      check("rel_in_ready", 69'(in_ready), 69'h1f);
      check("rel_level",    69'(level), 69'h0);

      // Single AW beat into an empty slice
      aw_exp = {4'h3, 32'h1000, 8'd7, 3'd2, 2'd1, 1'b0, 4'h3, 3'd0, 4'd0, 4'd0, 4'h5};
      send(0, aw_exp);
      in_valid[0] = 1'b0;
      check("aw_out_valid", 69'(out_valid[0]), 69'h1);
      check("aw_payload",   fld(out_pld, 0), aw_exp);
      check("aw_level",     69'(level[1:0]), 69'h1);
      check("aw_idle",      69'(idle), 69'h0);
      tick();
      tick();
      check("aw_level_held", 69'(level[1:0]), 69'h1);
      check("aw_payload_held", fld(out_pld, 0), aw_exp);
      out_ready[0] = 1'b1;
      tick();
      out_ready[0] = 1'b0;
      check("aw_popped_valid", 69'(out_valid[0]), 69'h0);
      check("aw_popped_level", 69'(level[1:0]), 69'h0);
      check("aw_popped_idle",  69'(idle), 69'h1);

      // Full stall on W
      send(1, {32'hA, 4'hF, 1'b0, 4'h0});
      check("w_ready_after_1", 69'(in_ready[1]), 69'h1);
      send(1, {32'hB, 4'hF, 1'b0, 4'h0});
      check("w_ready_after_2", 69'(in_ready[1]), 69'h0);
      check("w_level_full",    69'(level[3:2]), 69'h2);
      drive(1, {32'hC, 4'hF, 1'b1, 4'h0});
      repeat (3) tick();
      check("w_third_held", 69'(in_ready[1]), 69'h0);
      check("w_queue_depth", 69'(exp_q[1].size()), 69'd2);
      tmp = fld(out_pld, 1);
      check("w_head_stable", 69'(tmp[40:9]), 69'hA);
      out_ready[1] = 1'b1;
      tick();
      check("w_ready_after_pop", 69'(in_ready[1]), 69'h1);
      tick();
      in_valid[1] = 1'b0;
      repeat (3) tick();
      out_ready[1] = 1'b0;
      check("w_count", 69'(w_seen.size()), 69'd3);
      if (w_seen.size() == 3) begin
         check("w_order_0", 69'(w_seen[0]), 69'hA);
         check("w_order_1", 69'(w_seen[1]), 69'hB);
         check("w_order_2", 69'(w_seen[2]), 69'hC);
      end

      // Streaming 16 R beats
      out_ready[4] = 1'b1;
      for (int i = 1; i <= 16; i++) send(4, r_beat(i));
      in_valid[4] = 1'b0;
      repeat (3) tick();
      out_ready[4] = 1'b0;
      check("r_beats", 69'(r_out_cyc.size()), 69'd16);
      if (r_out_cyc.size() == 16) begin
         check("r_latency", 69'(r_out_cyc[0] - r_in_first), 69'd1);
         for (int k = 1; k < 16; k++)
            check($sformatf("r_consec_%0d", k), 69'(r_out_cyc[k] - r_out_cyc[0]), 69'(k));
         for (int k = 0; k < 16; k++)
            check($sformatf("r_last_%0d", k), 69'(r_last[k]), 69'(k == 15));
      end

      // B is registered in the fully buffered slice
      drive(2, {4'd2, 2'b10, 4'h0});
      in_valid[2] = 1'b1;
      #1;
      check("b_buf_not_comb", 69'(out_valid[2]), 69'h0);
      tick();
      in_valid[2] = 1'b0;
      check("b_buf_valid", 69'(out_valid[2]), 69'h1);
      check("b_buf_level", 69'(level[5:4]), 69'h1);
      out_ready[2] = 1'b1;
      tick();
      out_ready[2] = 1'b0;
      check("b_buf_drained", 69'(out_valid[2]), 69'h0);

      // B pass-through slice
      in_pld2[110 +: 10] = {4'd2, 2'b10, 4'h0};
      in_valid2[2] = 1'b1;
      #1;
      check("pt_b_valid",   69'(out_valid2[2]), 69'h1);
      check("pt_b_payload", 69'(out_pld2[110 +: 10]), 69'h0a0);
      check("pt_b_ready_lo", 69'(in_ready2[2]), 69'h0);
      out_ready2[2] = 1'b1;
      #1;
      check("pt_b_ready_hi", 69'(in_ready2[2]), 69'h1);
      tick();
      check("pt_b_level", 69'(level2[5:4]), 69'h0);
      check("pt_idle",    69'(idle2), 69'h1);
      check("pt_aw_buffered_ready", 69'(in_ready2[0]), 69'h1);
      out_ready2[2] = 1'b0;
      #1;
      check("pt_b_ready_follows", 69'(in_ready2[2]), 69'h0);
      in_valid2[2] = 1'b0;
      #1;
      check("pt_b_valid_follows", 69'(out_valid2[2]), 69'h0);

      // Reset while AR holds two entries
      send(3, ar_beat(1));
      send(3, ar_beat(2));
      in_valid[3] = 1'b0;
      check("ar_level_2", 69'(level[7:6]), 69'h2);
      #1;
      aresetn = 1'b0;
      #1;
      check("ar_rst_valid", 69'(out_valid[3]), 69'h0);
      check("ar_rst_level", 69'(level[7:6]), 69'h0);
      check("ar_rst_idle",  69'(idle), 69'h1);
      check("ar_rst_ready", 69'(in_ready), 69'h0);
      check("ar_rst_pld",   fld(out_pld, 3), 69'h0);
      exp_q[3].delete();
      repeat (2) tick();
      aresetn = 1'b1;
      tick();
      check("ar_rel_level", 69'(level), 69'h0);
      check("ar_rel_idle",  69'(idle), 69'h1);
      check("ar_rel_ready", 69'(in_ready), 69'h1f);
      check("ar_rel_valid", 69'(out_valid), 69'h0);

      for (int c = 0; c < 5; c++)
         check($sformatf("sb_drained_ch%0d", c), 69'(exp_q[c].size()), 69'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axi4_reg_slice.md
# axi4_reg_slice

Parametrised AXI4 register slice covering all five channels (AW, W, B, AR, R), inserted between an AXI4 manager and subordinate to break timing paths. Each channel is an independently buffered, order-preserving valid/ready FIFO of configurable depth, or a combinational pass-through. Widths for ID, USER, address and data are generalised. Per-channel occupancy and an idle flag support debug and clock-gating decisions.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, AW/AR address width
- DATA_WIDTH, 32, W/R data width (multiple of 8; strobe = DATA_WIDTH/8)
- ID_WIDTH, 4, AxID/BID/RID width
- USER_WIDTH, 4, width of every xUSER field
- DEPTH, 2, entries per buffered channel (power of 2, ≥2)
- CHAN_EN, 5'b11111, bit c set = channel c buffered, clear = pass-through (AW=0, W=1, B=2, AR=3, R=4)

Ports (in = upstream side of flow, out = downstream; B/R flow subordinate→manager):
- aclk  in  1  clock
- aresetn  in  1  reset; asynchronous, active-low
- in_valid  in  5  per-channel valid, indexed by channel
- in_ready  out  5  per-channel ready
- in_pld  in  PLD_TOTAL  concatenated payloads, channel 0 at LSB
- out_valid  out  5  per-channel valid
- out_ready  in  5  per-channel ready
- out_pld  out  PLD_TOTAL  concatenated payloads, same layout
- level  out  5*LW  per-channel occupancy, LW = $clog2(DEPTH+1)
- idle  out  1  high when every level is 0

## Operation
- Payload field order, MSB→LSB: AW/AR: id, addr, len[7:0], size[2:0], burst[1:0], lock, cache[3:0], prot[2:0], qos[3:0], region[3:0], user. W: data, strb, last, user. B: id, resp[1:0], user. R: id, data, resp[1:0], last, user.
- Buffered channel: push on in_valid&&in_ready; pop on out_valid&&out_ready; strict FIFO order within the channel; no ordering between channels (W may precede AW).
- out_valid = (count≠0), driven from a flop; out_pld = head entry, registered. It holds stable while out_valid&&!out_ready.
- in_ready = (count<DEPTH), driven from a flop. There is no combinational path from out_ready to in_ready.
- Simultaneous push and pop: count is unchanged and the data order is preserved. When full, in_ready=0, so no push occurs.
- Pointers wrap modulo DEPTH. count is range 0..DEPTH.
- Pass-through channel: out_valid=in_valid, in_ready=out_ready, out_pld=in_pld combinationally. Its level field is 0.
- idle is combinational from the count registers.

## Timing
- While aresetn=0: all out_valid=0, in_ready=0, out_pld=0, level=0, idle=1, pointers=0.
- in_ready for buffered channels rises on the first aclk edge after aresetn deasserts.
- Latency into an empty channel is 1 cycle: accepted at edge N, out_valid high after edge N.
- Throughput is one beat per cycle per channel in steady state for DEPTH≥2.
- Full at edge N with a pop at N: in_ready is high after edge N.
- Reset asserted mid-burst: all contents are discarded immediately and asynchronously. No partial state survives.

## Structure
- Add to axi4_globals_pkg:
  - channel index constants AXI4_CH_AW..AXI4_CH_R;
  - functions computing each channel's payload width and PLD_TOTAL/offsets from (ADDRESS_WIDTH, DATA_WIDTH, ID_WIDTH, USER_WIDTH);
  - resp encodings.
- Sub-module axi4_chan_fifo (WIDTH, DEPTH) implements one buffered channel, including registered in_ready and out_valid, pointers and count.
- The top level instantiates five copies under generate, selecting on CHAN_EN, and slices in_pld/out_pld.

## Test plan
- Reset, all channels idle:
  - During reset: in_ready=0, out_valid=0, idle=1.
  - One cycle after release: in_ready=5'b11111, level=0.
- Single AW beat, id=4'h3, addr=32'h1000, len=8'd7, into an empty slice:
  - out_valid[0] high one cycle later with an identical payload.
  - level[AW]=1 until popped.
- Full stall, DEPTH=2, out_ready[W]=0, push 3 W beats:
  - first two accepted, in_ready[1]=0 after the second;
  - third held until out_ready asserts;
  - output order preserved as data 0xA, 0xB, 0xC.
- Streaming, out_ready=1, in_valid held high on R for 16 beats:
  - 16 beats out in 16 consecutive cycles after 1-cycle latency;
  - last set only on beat 16.
- CHAN_EN=5'b11011 (B pass-through):
  - B response (bid=2, bresp=2'b10) appears on out_pld the same cycle;
  - in_ready[2] tracks out_ready[2] combinationally;
  - level[B]=0.
- Reset mid-operation, AR holding 2 entries: assert aresetn=0 between edges → out_valid[3] falls immediately, level[AR]=0 and idle=1 after release.
